// File: rtl/shk_pkg.sv
// Shared shake-bus definitions: sync-word field positions, opcodes, status codes and the
// slave FSM state encoding.
package shk_pkg;

    localparam int unsigned SHK_SEL_LSB  = 0;
    localparam int unsigned SHK_SEL_MSB  = 7;
    localparam int unsigned SHK_OP_LSB   = 8;
    localparam int unsigned SHK_OP_MSB   = 9;
    localparam int unsigned SHK_ADDR_LSB = 10;
    localparam int unsigned SHK_ADDR_MSB = 15;
    localparam int unsigned SHK_ADDR_W   = 6;

    localparam logic [1:0] SHK_OP_NOP   = 2'b00;
    localparam logic [1:0] SHK_OP_WRITE = 2'b01;
    localparam logic [1:0] SHK_OP_READ  = 2'b10;
    localparam logic [1:0] SHK_OP_ILL   = 2'b11;

    localparam logic [1:0] SHK_ST_OK       = 2'b00;
    localparam logic [1:0] SHK_ST_BAD_ADDR = 2'b01;
    localparam logic [1:0] SHK_ST_BAD_OP   = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StAck,
        StWaitLow
    } shk_state_e;

endpackage

// File: rtl/shk_slv_decode.sv
// Combinational decode of a shake sync word: select hit, address, and the action/status the
// slave register bank should take.
module shk_slv_decode
    import shk_pkg::*;
#(
    parameter int unsigned WD_SHK_SYNC = 16,
    parameter int unsigned P_SLV_ID    = 0,
    parameter int unsigned P_NUM_REG   = 8
) (
    input  logic [WD_SHK_SYNC-1:0] smosi_i,
    output logic                   hit_o,
    output logic [7:0]             sel_o,
    output logic [SHK_ADDR_W-1:0]  addr_o,
    output logic [1:0]             status_o,
    output logic                   wr_reg_o,
    output logic                   rd_reg_o,
    output logic                   rd_sts_o
);

    localparam logic [SHK_ADDR_W-1:0] STS_ADDR = SHK_ADDR_W'(P_NUM_REG);

    logic [1:0] op;

    assign hit_o  = smosi_i[P_SLV_ID];
    assign sel_o  = smosi_i[SHK_SEL_MSB:SHK_SEL_LSB];
    assign op     = smosi_i[SHK_OP_MSB:SHK_OP_LSB];
    assign addr_o = smosi_i[SHK_ADDR_MSB:SHK_ADDR_LSB];

    always_comb begin
        status_o = SHK_ST_OK;
        wr_reg_o = 1'b0;
        rd_reg_o = 1'b0;
        rd_sts_o = 1'b0;
        case (op)
            SHK_OP_NOP: begin
            end
            SHK_OP_WRITE: begin
                // The status word is read-only, so writing it is an address error.
                if (addr_o < STS_ADDR) begin
                    wr_reg_o = 1'b1;
                end else begin
                    status_o = SHK_ST_BAD_ADDR;
                end
            end
            SHK_OP_READ: begin
                if (addr_o < STS_ADDR) begin
                    rd_reg_o = 1'b1;
                end else if (addr_o == STS_ADDR) begin
                    rd_sts_o = 1'b1;
                end else begin
                    status_o = SHK_ST_BAD_ADDR;
                end
            end
            default: status_o = SHK_ST_BAD_OP;
        endcase
    end

endmodule

// File: rtl/shk_slave_regs.sv
// Shake-bus slave endpoint: decodes a request addressed to this slave, accesses a small register
// bank, and answers with a one-cycle wready plus status and read data.
module shk_slave_regs
    import shk_pkg::*;
#(
    parameter int unsigned WD_SHK_SYNC = 16,
    parameter int unsigned WD_SHK_DLAY = 15,
    parameter int unsigned P_SLV_ID    = 0,
    parameter int unsigned P_NUM_REG   = 8
) (
    input  logic                             i_sys_clk,
    input  logic                             i_sys_resetn,
    input  logic                             s_shk_wvalid,
    input  logic [WD_SHK_SYNC-1:0]           s_shk_smosi,
    input  logic [WD_SHK_DLAY-1:0]           s_shk_dmosi,
    output logic                             s_shk_wready,
    output logic [WD_SHK_SYNC-1:0]           s_shk_smiso,
    output logic [WD_SHK_DLAY-1:0]           s_shk_dmiso,
    input  logic [WD_SHK_DLAY-1:0]           i_sts,
    output logic [P_NUM_REG*WD_SHK_DLAY-1:0] o_reg_bus,
    output logic [P_NUM_REG-1:0]             o_reg_wstb
);

    shk_state_e state_q, state_d;

    logic                  dec_hit;
    logic [7:0]            dec_sel;
    logic [SHK_ADDR_W-1:0] dec_addr;
    logic [1:0]            dec_status;
    logic                  dec_wr_reg;
    logic                  dec_rd_reg;
    logic                  dec_rd_sts;

    logic [7:0]             req_sel_q;
    logic [SHK_ADDR_W-1:0]  req_addr_q;
    logic [1:0]             req_status_q;
    logic                   req_wr_reg_q;
    logic                   req_rd_reg_q;
    logic                   req_rd_sts_q;
    logic [WD_SHK_DLAY-1:0] req_data_q;

    logic [WD_SHK_DLAY-1:0] reg_q [P_NUM_REG];
    logic [P_NUM_REG-1:0]   wstb;
    logic [WD_SHK_DLAY-1:0] rd_data;
    logic [WD_SHK_SYNC-1:0] smiso_d;
    logic [WD_SHK_SYNC-1:0] smiso_q;
    logic [WD_SHK_DLAY-1:0] dmiso_q;
    logic                   accept;

    shk_slv_decode #(
        .WD_SHK_SYNC (WD_SHK_SYNC),
        .P_SLV_ID    (P_SLV_ID),
        .P_NUM_REG   (P_NUM_REG)
    ) u_decode (
        .smosi_i  (s_shk_smosi),
        .hit_o    (dec_hit),
        .sel_o    (dec_sel),
        .addr_o   (dec_addr),
        .status_o (dec_status),
        .wr_reg_o (dec_wr_reg),
        .rd_reg_o (dec_rd_reg),
        .rd_sts_o (dec_rd_sts)
    );

    assign accept = (state_q == StIdle) && s_shk_wvalid && dec_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = StExec;
            StExec:    state_d = StAck;
            StAck:     state_d = StWaitLow;
            StWaitLow: if (!s_shk_wvalid) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request is latched on accept so an early wvalid drop cannot corrupt EXEC.
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            req_sel_q    <= '0;
            req_addr_q   <= '0;
            req_status_q <= SHK_ST_OK;
            req_wr_reg_q <= 1'b0;
            req_rd_reg_q <= 1'b0;
            req_rd_sts_q <= 1'b0;
            req_data_q   <= '0;
        end else if (accept) begin
            req_sel_q    <= dec_sel;
            req_addr_q   <= dec_addr;
            req_status_q <= dec_status;
            req_wr_reg_q <= dec_wr_reg;
            req_rd_reg_q <= dec_rd_reg;
            req_rd_sts_q <= dec_rd_sts;
            req_data_q   <= s_shk_dmosi;
        end
    end

    always_comb begin
        wstb = '0;
        for (int unsigned k = 0; k < P_NUM_REG; k++) begin
            wstb[k] = (state_q == StExec) && req_wr_reg_q && (req_addr_q == SHK_ADDR_W'(k));
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            for (int unsigned k = 0; k < P_NUM_REG; k++) begin
                reg_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < P_NUM_REG; k++) begin
                if (wstb[k]) begin
                    reg_q[k] <= req_data_q;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (req_rd_sts_q) begin
            rd_data = i_sts;
        end
        for (int unsigned k = 0; k < P_NUM_REG; k++) begin
            if (req_rd_reg_q && (req_addr_q == SHK_ADDR_W'(k))) begin
                rd_data = reg_q[k];
            end
        end
        smiso_d = '0;
        smiso_d[SHK_SEL_MSB:SHK_SEL_LSB] = req_sel_q;
        smiso_d[SHK_OP_MSB:SHK_OP_LSB]   = req_status_q;
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            smiso_q <= '0;
            dmiso_q <= '0;
        end else if (state_q == StExec) begin
            smiso_q <= smiso_d;
            dmiso_q <= rd_data;
        end else if ((state_q == StWaitLow) && !s_shk_wvalid) begin
            smiso_q <= '0;
            dmiso_q <= '0;
        end
    end

    always_comb begin
        o_reg_bus = '0;
        for (int unsigned k = 0; k < P_NUM_REG; k++) begin
            o_reg_bus[k*WD_SHK_DLAY +: WD_SHK_DLAY] = reg_q[k];
        end
    end

    assign s_shk_wready = (state_q == StAck);
    assign s_shk_smiso  = smiso_q;
    assign s_shk_dmiso  = dmiso_q;
    assign o_reg_wstb   = wstb;

endmodule

// File: tb/tb_shk_slave_regs.sv
// Randomized self-checking bench for shk_slave_regs against a transaction-level register model.
module tb_shk_slave_regs;

    localparam int unsigned SLV = 2;
    localparam int unsigned NREG = 8;
    localparam int unsigned WD = 15;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            wvalid = 1'b0;
    logic [15:0]     smosi = '0;
    logic [WD-1:0]   dmosi = '0;
    logic            wready;
    logic [15:0]     smiso;
    logic [WD-1:0]   dmiso;
    logic [WD-1:0]   sts = '0;
    logic [NREG*WD-1:0] reg_bus;
    logic [NREG-1:0] reg_wstb;

    logic [WD-1:0] model_regs [NREG];
    int n_checks = 0;
    int n_errors = 0;

    shk_slave_regs #(
        .WD_SHK_SYNC (16),
        .WD_SHK_DLAY (WD),
        .P_SLV_ID    (SLV),
        .P_NUM_REG   (NREG)
    ) dut (
        .i_sys_clk    (clk),
        .i_sys_resetn (resetn),
        .s_shk_wvalid (wvalid),
        .s_shk_smosi  (smosi),
        .s_shk_dmosi  (dmosi),
        .s_shk_wready (wready),
        .s_shk_smiso  (smiso),
        .s_shk_dmiso  (dmiso),
        .i_sts        (sts),
        .o_reg_bus    (reg_bus),
        .o_reg_wstb   (reg_wstb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREG*WD-1:0] model_bus();
        logic [NREG*WD-1:0] b;
        for (int k = 0; k < NREG; k++) b[k*WD +: WD] = model_regs[k];
        return b;
    endfunction

    // One full request/response handshake, checked cycle by cycle against the model.
    task automatic txn(input logic [7:0] sel, input logic [1:0] op, input logic [5:0] addr,
                       input logic [WD-1:0] wdata, input int extra_hold);
        logic            hit;
        logic [1:0]      status;
        logic [WD-1:0]   exp_d;
        logic [NREG-1:0] exp_stb;
        int n_rdy, first_rdy, n_stb;
        hit = sel[SLV];
        status = 2'b00;
        exp_d = '0;
        exp_stb = '0;
        if (op == 2'b01) begin
            if (addr < NREG) exp_stb = NREG'(1) << addr;
            else status = 2'b01;
        end else if (op == 2'b10) begin
            if (addr < NREG) exp_d = model_regs[addr];
            else if (addr == NREG) exp_d = sts;
            else status = 2'b01;
        end else if (op == 2'b11) begin
            status = 2'b10;
        end
        if (!hit) exp_stb = '0;
        if (exp_stb != 0) model_regs[addr] = wdata;

        @(posedge clk); #1;
        wvalid = 1'b1;
        smosi = {addr, op, sel};
        dmosi = wdata;
        n_rdy = 0;
        first_rdy = -1;
        n_stb = 0;
        for (int i = 0; i < 4 + extra_hold; i++) begin
            @(negedge clk);
            if (wready) begin
                n_rdy++;
                if (first_rdy < 0) first_rdy = i;
                check("ack_smiso", smiso, {6'b0, status, sel});
                check("ack_dmiso", dmiso, exp_d);
            end
            if (reg_wstb != 0) begin
                n_stb++;
                check("wstb_value", reg_wstb, exp_stb);
            end
        end
        if (hit) begin
            check("held_smiso", smiso, {6'b0, status, sel});
            check("latency", first_rdy, 2);
        end
        check("wready_count", n_rdy, hit ? 1 : 0);
        check("wstb_count", n_stb, (exp_stb != 0) ? 1 : 0);
        @(posedge clk); #1;
        wvalid = 1'b0;
        smosi = $urandom;
        dmosi = $urandom;
        @(negedge clk);
        @(negedge clk);
        check("idle_smiso", smiso, 0);
        check("idle_dmiso", dmiso, 0);
        check("reg_bus", reg_bus, model_bus());
    endtask

    initial begin
        logic [7:0] rsel;
        int n_rdy;
        for (int k = 0; k < NREG; k++) model_regs[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_wready", wready, 0);
        check("rst_smiso", smiso, 0);
        check("rst_dmiso", dmiso, 0);
        check("rst_bus", reg_bus, 0);
        check("rst_wstb", reg_wstb, 0);
        resetn = 1'b1;

        txn(8'h04, 2'b01, 6'd3, 15'h1234, 0);
        txn(8'h04, 2'b10, 6'd3, 15'h0, 0);
        sts = 15'h5A5A;
        txn(8'h04, 2'b10, 6'd8, 15'h0, 0);
        txn(8'h04, 2'b01, 6'd9, 15'h7777, 0);
        txn(8'h04, 2'b01, 6'd8, 15'h6666, 0);
        txn(8'h04, 2'b11, 6'd3, 15'h1111, 0);
        txn(8'h04, 2'b00, 6'd3, 15'h2222, 0);
        txn(8'h85, 2'b01, 6'd0, 15'h0ABC, 0);
        txn(8'h01, 2'b01, 6'd1, 15'h3333, 10);
        txn(8'h04, 2'b01, 6'd7, 15'h4321, 6);
        txn(8'h04, 2'b01, 6'd7, 15'h1357, 3);

        for (int n = 0; n < 60; n++) begin
            rsel = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rsel[SLV] = 1'b1;
            sts = WD'($urandom);
            txn(rsel, 2'($urandom), 6'($urandom_range(0, 10)), WD'($urandom),
                int'($urandom_range(0, 3)));
        end

        // Reset asserted while the acknowledge is on the bus.
        @(posedge clk); #1;
        wvalid = 1'b1;
        smosi = {6'd5, 2'b01, 8'h04};
        dmosi = 15'h7FFF;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_wready", wready, 1);
        resetn = 1'b0;
        #1;
        for (int k = 0; k < NREG; k++) model_regs[k] = '0;
        check("midrst_wready", wready, 0);
        check("midrst_smiso", smiso, 0);
        check("midrst_dmiso", dmiso, 0);
        check("midrst_bus", reg_bus, 0);
        check("midrst_wstb", reg_wstb, 0);
        wvalid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        n_rdy = 0;
        repeat (5) begin
            @(negedge clk);
            if (wready) n_rdy++;
        end
        check("postrst_no_wready", n_rdy, 0);
        txn(8'h04, 2'b10, 6'd5, 15'h0, 0);
        txn(8'h04, 2'b01, 6'd2, 15'h0F0F, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
